// File: rtl/xls_pipe_credit_adapter.sv
// Credit-based valid/ready wrapper around a free-running, fixed-latency XLS pipeline.
// Latency: accept in cycle T -> FIFO write at end of T+LATENCY -> out_valid earliest in T+LATENCY+1.
// Backpressure: in_ready_o drops when no credits remain; credits return one cycle after each pop.
module xls_pipe_credit_adapter #(
  parameter int unsigned       DATA_W  = 1,
  parameter int unsigned       LATENCY = 2,
  parameter int unsigned       DEPTH   = 4,
  parameter logic [DATA_W-1:0] IDLE_X  = '1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       in_pred_i,
  input  logic [DATA_W-1:0]          in_x_i,
  output logic                       pipe_pred_o,
  output logic [DATA_W-1:0]          pipe_x_o,
  input  logic [DATA_W-1:0]          pipe_out_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] credits_o,
  output logic                       overflow_err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0]   credits_q, credits_d;
  logic               in_ready_q;
  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q;

  logic accept, push, pop, full, wr_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept      = in_valid_i & in_ready_q;
  assign push        = vld_q[LATENCY-1];
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign full        = (count_q == CNT_W'(DEPTH));
  // A pop in the same cycle frees the slot being written, so a full FIFO can still take a push.
  assign wr_en       = push & (~full | pop);

  // Pipeline inputs: token when accepted, otherwise a harmless idle value.
  assign pipe_pred_o = accept ? in_pred_i : 1'b0;
  assign pipe_x_o    = accept ? in_x_i : IDLE_X;

  assign in_ready_o     = in_ready_q;
  assign out_data_o     = mem_q[rd_ptr_q];
  assign credits_o      = credits_q;
  assign overflow_err_o = overflow_q;

  // Credit next-state: accept spends one, pop returns one, both cancel.
  always_comb begin
    credits_d = credits_q;
    if (accept && !pop)      credits_d = credits_q - CNT_W'(1);
    else if (!accept && pop) credits_d = credits_q + CNT_W'(1);
  end

  // FIFO occupancy next-state.
  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
  end

  // Credits and the registered ready derived from the post-update credit count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits_q  <= CNT_W'(DEPTH);
      in_ready_q <= 1'b1;
    end else begin
      credits_q  <= credits_d;
      in_ready_q <= (credits_d != '0);
    end
  end

  // Tag shift register tracks which pipeline stages hold real tokens.
  generate
    if (LATENCY == 1) begin : g_tag1
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vld_q <= '0;
        else         vld_q <= accept;
      end
    end else begin : g_tagn
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vld_q <= '0;
        else         vld_q <= {vld_q[LATENCY-2:0], accept};
      end
    end
  endgenerate

  // Capture FIFO storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= pipe_out_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xls_pipe_credit_adapter.sv
// Bench for xls_pipe_credit_adapter with an 8-bit, 2-cycle behavioural pipeline.
// Expected output values are queued at accept time and compared when popped.
module tb_xls_pipe_credit_adapter;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_pred;
  logic [DW-1:0] in_x;
  logic          pipe_pred;
  logic [DW-1:0] pipe_x, pipe_out;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    credits;
  logic          overflow_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  xls_pipe_credit_adapter #(
    .DATA_W(DW), .LATENCY(2), .DEPTH(4), .IDLE_X(8'hFF)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_pred_i(in_pred), .in_x_i(in_x),
    .pipe_pred_o(pipe_pred), .pipe_x_o(pipe_x), .pipe_out_i(pipe_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .credits_o(credits), .overflow_err_o(overflow_err)
  );

  // Free-running pipeline model: no reset, no stall, two register stages.
  function automatic logic [DW-1:0] pipe_fn(input logic p, input logic [DW-1:0] x);
    return p ? x : ~x;
  endfunction

  logic [DW-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= pipe_fn(pipe_pred, pipe_x);
    p2 <= p1;
  end
  assign pipe_out = p2;

  // Record an accepted token's expected result, then advance to just after the next edge.
  task automatic step();
    if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(pipe_fn(in_pred, in_x));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_pred = 1'b0; in_x = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (credits !== 3'd4)     begin n_fail++; $display("FAIL reset_credits got %0d want 4", credits); end
    n_checks++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h00)   begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow_err); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [DW-1:0] e;
    in_valid = 1'b1; in_pred = 1'b1; in_x = 8'h01; out_ready = 1'b1; #1;
    n_checks++; if (pipe_x !== 8'h01)   begin n_fail++; $display("FAIL single_pipe_x got %h want 01", pipe_x); end
    n_checks++; if (pipe_pred !== 1'b1) begin n_fail++; $display("FAIL single_pipe_pred got %b want 1", pipe_pred); end
    step();
    in_valid = 1'b0; #1;
    n_checks++; if (credits !== 3'd3)   begin n_fail++; $display("FAIL single_credits_t1 got %0d want 3", credits); end
    n_checks++; if (pipe_x !== 8'hFF)   begin n_fail++; $display("FAIL single_idle_x got %h want ff", pipe_x); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_t1 got %b want 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_t2 got %b want 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_t3 got %b want 1", out_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++; if (out_data !== e)     begin n_fail++; $display("FAIL single_data got %h want %h", out_data, e); end
    n_checks++; if (out_data !== 8'h01) begin n_fail++; $display("FAIL single_data_abs got %h want 01", out_data); end
    step();
    n_checks++; if (credits !== 3'd4)   begin n_fail++; $display("FAIL single_credits_t4 got %0d want 4", credits); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_t4 got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic [DW-1:0] e;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_pred = i[0]; in_x = 8'h10 + 8'(i); #1;
      n_checks++;
      if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want %b", i, in_ready, (i < 4)); end
      if (in_ready === 1'b1) acc++;
      else begin
        n_checks++; if (pipe_x !== 8'hFF) begin n_fail++; $display("FAIL bp_idle_x[%0d] got %h want ff", i, pipe_x); end
      end
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepts got %0d want 4", acc); end
    repeat (3) step();
    n_checks++; if (credits !== 3'd0)   begin n_fail++; $display("FAIL bp_credits_full got %0d want 0", credits); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_full got %b want 1", out_valid); end
    // Full FIFO: pop and offer a token in the same cycle; the token must wait one cycle.
    in_valid = 1'b1; in_pred = 1'b1; in_x = 8'h55; out_ready = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_on_pop got %b want 0", in_ready); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++; if (out_data !== e)    begin n_fail++; $display("FAIL bp_pop_data got %h want %h", out_data, e); end
    step();
    out_ready = 1'b0; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_reconsumed got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_drain_extra got %h want none", out_data); end
        else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin n_fail++; $display("FAIL bp_drain_data got %h want %h", out_data, e); end
        end
      end
      step();
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain_left got %0d want 0", exp_q.size()); end
    n_checks++; if (credits !== 3'd4)  begin n_fail++; $display("FAIL bp_credits_end got %0d want 4", credits); end
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    logic [DW-1:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 28; i++) begin
      in_valid = (i < 20); in_pred = 1'($urandom_range(0, 1)); in_x = 8'($urandom_range(0, 255)); #1;
      if (i < 20) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
        n_checks++; if (credits === 3'd0)  begin n_fail++; $display("FAIL b2b_credits[%0d] got 0 want nonzero", i); end
      end
      if (out_valid === 1'b1) begin
        pops++;
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra got %h want none", out_data); end
        else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", pops, out_data, e); end
        end
      end
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (pops != 20)        begin n_fail++; $display("FAIL b2b_pops got %0d want 20", pops); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pred = 1'b1; in_x = 8'hA0 + 8'(i);
      step();
    end
    in_valid = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rif_valid_before got %b want 1", out_valid); end
    rst_n = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rif_valid_async got %b want 0", out_valid); end
    n_checks++; if (credits !== 3'd4)   begin n_fail++; $display("FAIL rif_credits got %0d want 4", credits); end
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rif_in_ready got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rif_ghost[%0d] got %b want 0", i, out_valid); end
      step();
    end
    n_checks++; if (credits !== 3'd4) begin n_fail++; $display("FAIL rif_credits_end got %0d want 4", credits); end
  endtask

  task automatic test_idle();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++; if (pipe_x !== 8'hFF)   begin n_fail++; $display("FAIL idle_x[%0d] got %h want ff", i, pipe_x); end
      n_checks++; if (pipe_pred !== 1'b0) begin n_fail++; $display("FAIL idle_pred[%0d] got %b want 0", i, pipe_pred); end
      step();
    end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL overflow_final got %b want 0", overflow_err); end
    n_checks++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL idle_valid got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_inflight();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
